// File: rtl/out_drain.sv
// out_drain: reads the T x M result matrix back from the 16 x 64-bit output
// SRAM and streams the valid elements out one at a time, in row-major order,
// over a valid/ready interface. Padding rows and columns are never emitted.
//
// Ports
//   CLK, RST       clock; asynchronous active-high reset
//   START, MNT     one-cycle request (sampled in IDLE); M=MNT[11:8], T=MNT[3:0]
//   EN_O, RW_O,    output SRAM read port: chip select, direction (always read),
//   ADDR_O,        address, and read data (valid the cycle after EN_O)
//   RDATA_O
//   DOUT_*         element stream: value, row/col index, last flag, handshake
//   BUSY, DONE,    status: not idle, end-of-drain pulse, illegal-dimension flag
//   ERR
//
// state | meaning
// IDLE  | waiting for START
// CHECK | validate latched M and T
// READ  | EN_O high for one cycle at address 2*row+word
// CAP   | capture RDATA_O into the word buffer
// SEND  | present buffered elements to the consumer
// FIN   | one-cycle DONE pulse
module out_drain #(
   parameter int DW = 16,
   parameter int MW = 64,
   parameter int AW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [11:0]   MNT,
   output logic          EN_O,
   output logic          RW_O,
   output logic [AW-1:0] ADDR_O,
   input  logic [MW-1:0] RDATA_O,
   output logic          DOUT_VALID,
   input  logic          DOUT_READY,
   output logic [DW-1:0] DOUT,
   output logic [2:0]    DOUT_ROW,
   output logic [2:0]    DOUT_COL,
   output logic          DOUT_LAST,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      READ  = 3'd2,
      CAP   = 3'd3,
      SEND  = 3'd4,
      FIN   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    m_q, m_d;
   logic [3:0]    t_q, t_d;
   logic [2:0]    row_q, row_d;
   logic [2:0]    col_q, col_d;
   logic          word_q, word_d;
   logic [MW-1:0] buf_q, buf_d;
   logic          err_q, err_d;

   logic [3:0]    col_inc;
   logic [3:0]    row_inc;
   logic          last_elem;
   logic [1:0]    lane;

   assign col_inc   = {1'b0, col_q} + 4'd1;
   assign row_inc   = {1'b0, row_q} + 4'd1;
   assign last_elem = (row_inc == t_q) && (col_inc == m_q);
   assign lane      = col_q[1:0];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         m_q     <= '0;
         t_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         word_q  <= 1'b0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         t_q     <= t_d;
         row_q   <= row_d;
         col_q   <= col_d;
         word_q  <= word_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      t_d     = t_q;
      row_d   = row_q;
      col_d   = col_q;
      word_d  = word_q;
      buf_d   = buf_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               m_d     = MNT[11:8];
               t_d     = MNT[3:0];
               err_d   = 1'b0;
               row_d   = '0;
               col_d   = '0;
               word_d  = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if ((m_q == 4'd0) || (m_q > 4'd8) || (t_q == 4'd0) || (t_q > 4'd8)) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               state_d = READ;
            end
         end
         READ: begin
            state_d = CAP;
         end
         CAP: begin
            buf_d   = RDATA_O;
            col_d   = word_q ? 3'd4 : 3'd0;
            state_d = SEND;
         end
         SEND: begin
            if (DOUT_READY) begin
               // col_inc landing on a multiple of 4 means this word is used up
               if ((col_inc < m_q) && (col_inc[1:0] != 2'd0)) begin
                  col_d = col_inc[2:0];
               end else if (last_elem) begin
                  state_d = FIN;
               end else if (col_inc < m_q) begin
                  word_d  = 1'b1;
                  state_d = READ;
               end else begin
                  row_d   = row_inc[2:0];
                  word_d  = 1'b0;
                  state_d = READ;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign EN_O       = (state_q == READ);
   assign RW_O       = 1'b0;
   assign ADDR_O     = AW'({row_q, word_q});
   assign DOUT_VALID = (state_q == SEND);
   // Column k%4 sits MSB-first within the word
   assign DOUT       = buf_q[MW-1-DW*lane -: DW];
   assign DOUT_ROW   = row_q;
   assign DOUT_COL   = col_q;
   assign DOUT_LAST  = (state_q == SEND) && last_elem;
   assign BUSY       = (state_q != IDLE);
   assign DONE       = (state_q == FIN);
   assign ERR        = err_q;

endmodule

// File: tb/tb_out_drain.sv
module tb_out_drain;
   localparam int DW = 16;
   localparam int MW = 64;
   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic [11:0]   MNT;
   logic          EN_O;
   logic          RW_O;
   logic [AW-1:0] ADDR_O;
   logic [MW-1:0] RDATA_O;
   logic          DOUT_VALID;
   logic          DOUT_READY = 1'b0;
   logic [DW-1:0] DOUT;
   logic [2:0]    DOUT_ROW;
   logic [2:0]    DOUT_COL;
   logic          DOUT_LAST;
   logic          BUSY;
   logic          DONE;
   logic          ERR;

   out_drain #(.DW(DW), .MW(MW), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
      .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .RDATA_O(RDATA_O),
      .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT(DOUT),
      .DOUT_ROW(DOUT_ROW), .DOUT_COL(DOUT_COL), .DOUT_LAST(DOUT_LAST),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   typedef struct packed {
      logic [2:0]  row;
      logic [2:0]  col;
      logic [15:0] data;
      logic        last;
   } elem_t;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [MW-1:0] mem [16];
   elem_t       exp_q[$];
   logic [3:0]  addr_q[$];
   int          done_cnt = 0;
   int          ready_mode = 0;
   int          rcyc = 0;
   logic        stall_prev = 1'b0;
   elem_t       stall_val;

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (EN_O) RDATA_O <= mem[ADDR_O];

   // READY pattern: mode 0 always ready, mode 1 repeats 1,0,0
   always @(posedge CLK) begin
      #1;
      if (ready_mode == 0) DOUT_READY = 1'b1;
      else begin
         DOUT_READY = (rcyc % 3 == 0);
         rcyc++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] edata(input logic [7:0] s, input int r, input int c);
      return {s, 1'b0, 3'(r), 1'b0, 3'(c)};
   endfunction

   // Monitor / scoreboard
   always @(negedge CLK) begin
      if (RST) begin
         stall_prev = 1'b0;
      end else begin
         if (EN_O) begin
            chk("rw_o", {63'b0, RW_O}, 64'd0);
            if (addr_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_read: got addr %0d expected no read", ADDR_O);
            end else begin
               chk("read_addr", {60'b0, ADDR_O}, {60'b0, addr_q.pop_front()});
            end
         end
         if (stall_prev)
            chk("stall_hold", {41'b0, DOUT_VALID, DOUT_ROW, DOUT_COL, DOUT, DOUT_LAST},
                {41'b0, 1'b1, stall_val});
         if (DOUT_VALID && DOUT_READY) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_elem: got row %0d col %0d data %h", DOUT_ROW, DOUT_COL, DOUT);
            end else begin
               chk("elem", {41'b0, DOUT_ROW, DOUT_COL, DOUT, DOUT_LAST}, {41'b0, exp_q.pop_front()});
            end
         end
         stall_prev = DOUT_VALID && !DOUT_READY;
         stall_val  = {DOUT_ROW, DOUT_COL, DOUT, DOUT_LAST};
         if (DONE) done_cnt++;
      end
   end

   task automatic load(input logic [11:0] mnt, input logic [7:0] seed);
      int m = int'(mnt[11:8]);
      int t = int'(mnt[3:0]);
      logic [MW-1:0] w;
      elem_t e;
      for (int a = 0; a < 16; a++) begin
         for (int k = 0; k < 4; k++) w[63-16*k -: 16] = edata(seed, a / 2, (a % 2) * 4 + k);
         mem[a] = w;
      end
      if (m >= 1 && m <= 8 && t >= 1 && t <= 8) begin
         for (int r = 0; r < t; r++) begin
            addr_q.push_back(4'(2 * r));
            if (m > 4) addr_q.push_back(4'(2 * r + 1));
            for (int c = 0; c < m; c++) begin
               e.row  = 3'(r);
               e.col  = 3'(c);
               e.data = edata(seed, r, c);
               e.last = (r == t - 1) && (c == m - 1);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic run(input logic [11:0] mnt, input logic [7:0] seed, input int rmode,
                      input logic exp_err, input int mid);
      int d0;
      int cyc = 0;
      load(mnt, seed);
      ready_mode = rmode;
      d0 = done_cnt;
      @(posedge CLK); #1;
      START = 1'b1;
      MNT   = mnt;
      @(posedge CLK); #1;
      START = 1'b0;
      @(negedge CLK);
      chk("err_cleared", {63'b0, ERR}, 64'd0);
      chk("busy_check", {63'b0, BUSY}, 64'd1);
      @(negedge CLK);
      if (exp_err) begin
         chk("err_done_cycle2", {62'b0, DONE, EN_O}, 64'd2);
      end else begin
         chk("first_read_cycle2", {59'b0, EN_O, ADDR_O}, {59'b0, 1'b1, 4'd0});
      end
      while (done_cnt == d0 && cyc < 3000) begin
         @(posedge CLK);
         cyc++;
         if (cyc == mid) begin
            #1;
            START = 1'b1;
            MNT   = 12'h888;
            @(posedge CLK); #1;
            START = 1'b0;
            cyc++;
         end
      end
      repeat (3) @(negedge CLK);
      chk("done_once", 64'(done_cnt - d0), 64'd1);
      chk("elems_left", 64'(exp_q.size()), 64'd0);
      chk("reads_left", 64'(addr_q.size()), 64'd0);
      chk("err_final", {63'b0, ERR}, {63'b0, exp_err});
      chk("idle_busy", {63'b0, BUSY}, 64'd0);
      exp_q.delete();
      addr_q.delete();
   endtask

   initial begin
      int k = 0;
      RST   = 1'b1;
      START = 1'b0;
      MNT   = '0;
      #3;
      chk("reset_outs", {50'b0, EN_O, DOUT_VALID, DOUT_LAST, BUSY, DONE, ERR, DOUT_ROW, DOUT_COL}, 64'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      run(12'h888, 8'h11, 0, 1'b0, 0);
      run(12'h302, 8'h22, 0, 1'b0, 0);
      run(12'h501, 8'h33, 1, 1'b0, 0);
      run(12'h008, 8'h44, 0, 1'b1, 0);
      run(12'h302, 8'h45, 0, 1'b0, 0);
      run(12'h302, 8'h46, 0, 1'b0, 5);

      // Reset during SEND
      ready_mode = 0;
      load(12'h888, 8'h55);
      @(posedge CLK); #1;
      START = 1'b1;
      MNT   = 12'h888;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (8) @(negedge CLK);
      while (!DOUT_VALID && k < 50) begin
         @(negedge CLK);
         k++;
      end
      chk("in_send_before_rst", {63'b0, DOUT_VALID}, 64'd1);
      #2;
      RST = 1'b1;
      #1;
      chk("async_rst_outs", {34'b0, EN_O, DOUT_VALID, DOUT_LAST, BUSY, DONE, ERR, DOUT_ROW, DOUT_COL, DOUT},
          64'd0);
      exp_q.delete();
      addr_q.delete();
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      run(12'h888, 8'h66, 0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/out_drain.md
Name: out_drain

Overview:
- Reader at the far end of the output SRAM. After the MAC array has written the T x M result matrix into the 16 x 64-bit output memory, out_drain reads it back and streams the valid elements out one at a time over a valid/ready interface.
- Unused padding columns (beyond M) and padding rows (beyond T) are never emitted.
- The block sits between OUT_MEM and the host or checker side. It shares the output SRAM port signalling used by the MAC array: EN_O, RW_O, ADDR_O, RDATA_O.

Parameters:
- DW, 16: element width; 4 elements per memory word.
- MW, 64: memory word width; must equal 4*DW.
- AW, 4: output memory address width (16 entries).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle request, sampled in IDLE only.
- MNT  in  12  matrix dimensions; M=MNT[11:8], N=MNT[7:4] (ignored), T=MNT[3:0]. Latched on accepted START.
- EN_O  out  1  output memory enable (chip select, active-high).
- RW_O  out  1  memory direction; tied 0 (read) at all times.
- ADDR_O  out  AW  memory read address.
- RDATA_O  in  MW  memory read data, valid the cycle after EN_O=1.
- DOUT_VALID  out  1  element valid.
- DOUT_READY  in  1  consumer ready.
- DOUT  out  DW  element value.
- DOUT_ROW  out  3  0-based row index of DOUT.
- DOUT_COL  out  3  0-based column index of DOUT.
- DOUT_LAST  out  1  high with the final element (row T-1, col M-1).
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at end of drain.
- ERR  out  1  high when the last accepted START had illegal dimensions; held until the next accepted START.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; row, column and word counters clear; the word buffer clears. Reset mid-operation aborts immediately; no further EN_O; partial output is discarded.
- Memory layout: row r (0-based) is stored at addr 2r (cols 0-3) and addr 2r+1 (cols 4-7). Within a word, col c%4=k occupies bits [MW-1-DW*k -: DW], so the first element is in the MSBs.
- Words per row: 1 if M<=4, else 2. Word 2r+1 is read only if M>4.
- FSM states: IDLE, CHECK, READ, CAP, SEND, FIN.
- IDLE: on START=1, latch M and T, clear ERR, go to CHECK. START is ignored in all other states.
- CHECK: if M==0, M>8, T==0 or T>8, set ERR and go to FIN with no memory access. Otherwise go to READ.
- READ: EN_O=1 and ADDR_O=2*row+word for exactly this one cycle; then go to CAP.
- CAP: latch RDATA_O into the 64-bit buffer; set col to the first column of the word (0 or 4); go to SEND.
- SEND: DOUT_VALID=1 with DOUT, DOUT_ROW and DOUT_COL taken from the buffer.
  - Handshake completes when VALID and READY are both high at a clock edge.
  - While VALID=1 and READY=0, DOUT, ROW, COL and LAST are held stable.
  - After a handshake: if the word still has columns left (col+1 < M and col+1 not a multiple of 4), increment col and stay in SEND. VALID stays high, so back-to-back elements flow 1 per cycle.
  - Otherwise advance to the next word or row and go to READ. DOUT_VALID is 0 in READ and CAP.
  - If the handshake was the final element, go to FIN.
- FIN: DONE=1 for one cycle, then go to IDLE. BUSY is high in CHECK through FIN.
- Latency: with START accepted at edge 0, EN_O is high in cycle 2 and the first DOUT_VALID appears in cycle 4.
- Throughput: per word, 2 overhead cycles plus min(4, remaining cols) element cycles, assuming READY=1.
- DOUT_LAST is asserted only with the final element and is held with it under backpressure.
- DONE and a new START never overlap, because START is only sampled in IDLE.

Test Plan:
- MNT=12'h888, memory preloaded with a row/col pattern, READY=1 -> 16 reads at addr 0..15 in order, 64 elements in row-major order, LAST on (7,7), DONE once, ERR=0.
- MNT=12'h302 (M=3, T=2) -> reads at addr 0 and 2 only, 6 elements (0,0..2),(1,0..2), addr 1 and 3 never enabled, LAST on (1,2).
- MNT=12'h501 (M=5, T=1) with READY toggling 1,0,0,1,... -> reads at addr 0 and 1, 5 elements, DOUT stable across every stalled cycle, no element dropped or duplicated.
- MNT=12'h008 (M=0) -> no EN_O pulse, ERR=1, DONE pulse 2 cycles after START; a following valid START clears ERR.
- START pulsed again mid-drain with a different MNT -> ignored; the original sequence completes unchanged.
- RST asserted during SEND of MNT=12'h888 -> all outputs 0 asynchronously; after release, a fresh START drains from (0,0) correctly.
